vga_image_wr_ctrl: RTL

- Write-side controller for the VGA image frame RAM (128 rows x 512 cols, address = {row[6:0], col[8:0]}).
- Arbitrates between two requesters:
  - single-pixel CPU writes from the AHB/APB bridge;
  - a rectangle-fill engine that streams a solid colour.
- Drives the image write port (image_we, address, image_data).
- Honours the image block's one-cycle internal address register: address leads we/data by exactly one cycle.

---
 rtl/vga_image_pkg.sv | 22 ++
 rtl/vga_fill_addr_gen.sv | 94 +++++++++
 rtl/vga_image_wr_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vga_image_pkg.sv
// Shared constants, FSM encoding and address helper for the image write side.
package vga_image_pkg;

    localparam int ROW_BITS  = 7;
    localparam int COL_BITS  = 9;
    localparam int IMG_ROWS  = 128;
    localparam int IMG_COLS  = 512;
    localparam int ADDR_BITS = 16;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FILL  = 2'd1,
        FS_DRAIN = 2'd2
    } fill_state_e;

    // Frame RAM address is the row index on top of the column index.
    function automatic logic [ADDR_BITS-1:0] img_addr(input logic [ROW_BITS-1:0] row,
                                                      input logic [COL_BITS-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_fill_addr_gen.sv
// Rectangle address generator: walks columns then rows, with the rectangle
// clipped to the frame at load time so no clipped slot is ever presented.
module vga_fill_addr_gen
    import vga_image_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [COL_BITS-1:0]  x0_i,
    input  logic [ROW_BITS-1:0]  y0_i,
    input  logic [COL_BITS:0]    w_i,
    input  logic [ROW_BITS:0]    h_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 valid_o,
    output logic                 last_o
);

    logic [COL_BITS:0]   room_w, eff_w;
    logic [ROW_BITS:0]   room_h, eff_h;
    logic [COL_BITS-1:0] col_q, col_d, x0_q, x0_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS:0]   wm1_q, wm1_d, colrem_q, colrem_d;
    logic [ROW_BITS:0]   rowrem_q, rowrem_d;
    logic                valid_q, valid_d;

    // Clip width/height against the frame edge so no write can wrap.
    always_comb begin
        room_w = (COL_BITS+1)'(IMG_COLS) - {1'b0, x0_i};
        room_h = (ROW_BITS+1)'(IMG_ROWS) - {1'b0, y0_i};
        eff_w  = (w_i > room_w) ? room_w : w_i;
        eff_h  = (h_i > room_h) ? room_h : h_i;
    end

    // Counter next-state: load a new rectangle or advance one pixel.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        x0_d     = x0_q;
        wm1_d    = wm1_q;
        colrem_d = colrem_q;
        rowrem_d = rowrem_q;
        valid_d  = valid_q;
        if (load_i) begin
            col_d    = x0_i;
            row_d    = y0_i;
            x0_d     = x0_i;
            wm1_d    = eff_w - 1'b1;
            colrem_d = eff_w - 1'b1;
            rowrem_d = eff_h - 1'b1;
            valid_d  = (w_i != '0) && (h_i != '0);
        end else if (step_i && valid_q) begin
            if (colrem_q == '0) begin
                if (rowrem_q == '0) begin
                    valid_d = 1'b0;
                end else begin
                    row_d    = row_q + 1'b1;
                    col_d    = x0_q;
                    colrem_d = wm1_q;
                    rowrem_d = rowrem_q - 1'b1;
                end
            end else begin
                col_d    = col_q + 1'b1;
                colrem_d = colrem_q - 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            x0_q     <= '0;
            wm1_q    <= '0;
            colrem_q <= '0;
            rowrem_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            x0_q     <= x0_d;
            wm1_q    <= wm1_d;
            colrem_q <= colrem_d;
            rowrem_q <= rowrem_d;
            valid_q  <= valid_d;
        end
    end

    assign addr_o  = img_addr(row_q, col_q);
    assign valid_o = valid_q;
    assign last_o  = valid_q && (colrem_q == '0) && (rowrem_q == '0);

endmodule

// File: rtl/vga_image_wr_ctrl.sv
// Image write-port controller: arbitrates CPU pixel writes against the
// rectangle fill engine; address leads image_we/image_data by one cycle.
module vga_image_wr_ctrl
    import vga_image_pkg::*;
#(
    parameter int PWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [PWIDTH-1:0]    cpu_data,
    output logic                 cpu_ack,
    input  logic                 fill_start,
    input  logic                 fill_abort,
    input  logic [COL_BITS-1:0]  fill_x0,
    input  logic [ROW_BITS-1:0]  fill_y0,
    input  logic [COL_BITS:0]    fill_w,
    input  logic [ROW_BITS:0]    fill_h,
    input  logic [PWIDTH-1:0]    fill_color,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 image_we,
    output logic [ADDR_BITS-1:0] address,
    output logic [PWIDTH-1:0]    image_data
);

    fill_state_e          state_q, state_d;
    logic [PWIDTH-1:0]    color_q, color_d;
    logic                 prio_fill_q, prio_fill_d;
    logic                 cpu_ack_q, pend_we_q, pend_we_d;
    logic [PWIDTH-1:0]    pend_data_q, pend_data_d;
    logic [ADDR_BITS-1:0] address_q, address_d;
    logic                 image_we_q;
    logic [PWIDTH-1:0]    image_data_q;
    logic                 fill_busy_q, fill_done_q, done_d;

    logic                 gen_load, gen_valid, gen_last;
    logic [ADDR_BITS-1:0] gen_addr;
    logic                 cpu_pend, fill_pend, grant_cpu, grant_fill;

    vga_fill_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (reset),
        .load_i  (gen_load),
        .step_i  (grant_fill),
        .x0_i    (fill_x0),
        .y0_i    (fill_y0),
        .w_i     (fill_w),
        .h_i     (fill_h),
        .addr_o  (gen_addr),
        .valid_o (gen_valid),
        .last_o  (gen_last)
    );

    // Slot arbitration, fill FSM next-state and write-slot selection.
    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        gen_load    = 1'b0;
        done_d      = 1'b0;
        // A request still high during its own ack cycle is the same request.
        cpu_pend    = cpu_req && !cpu_ack_q;
        fill_pend   = (state_q == FS_FILL) && gen_valid && !fill_abort;
        grant_cpu   = cpu_pend && (!fill_pend || !prio_fill_q);
        grant_fill  = fill_pend && !grant_cpu;
        prio_fill_d = (cpu_pend && fill_pend) ? !prio_fill_q : prio_fill_q;

        case (state_q)
            FS_IDLE: begin
                if (fill_start) begin
                    if ((fill_w != '0) && (fill_h != '0)) begin
                        gen_load = 1'b1;
                        color_d  = fill_color;
                        state_d  = FS_FILL;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FS_FILL: begin
                if (fill_abort || !gen_valid || (grant_fill && gen_last))
                    state_d = FS_DRAIN;
            end
            FS_DRAIN: begin
                done_d  = 1'b1;
                state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase

        pend_we_d   = grant_cpu || grant_fill;
        address_d   = grant_cpu ? cpu_addr : (grant_fill ? gen_addr : address_q);
        pend_data_d = grant_cpu ? cpu_data : (grant_fill ? color_q : pend_data_q);
    end

    // State, write pipeline and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            color_q      <= '0;
            prio_fill_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_data_q  <= '0;
            address_q    <= '0;
            image_we_q   <= 1'b0;
            image_data_q <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            prio_fill_q <= prio_fill_d;
            cpu_ack_q   <= grant_cpu;
            pend_we_q   <= pend_we_d;
            pend_data_q <= pend_data_d;
            address_q   <= address_d;
            image_we_q  <= pend_we_q;
            if (pend_we_q)
                image_data_q <= pend_data_q;
            fill_busy_q <= (state_d != FS_IDLE);
            fill_done_q <= done_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign fill_busy  = fill_busy_q;
    assign fill_done  = fill_done_q;
    assign image_we   = image_we_q;
    assign address    = address_q;
    assign image_data = image_data_q;

endmodule
